// File: rtl/pulse_emitter.sv
// Test-pulse transmitter: trains of pulses with programmable width, gap and count.
// Optional PULSE_EMITTER_RANDGAP_EN adds LFSR jitter (0..15 cycles) to every gap.
module pulse_emitter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_gap,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  output logic                 o_pulse,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulse_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

`ifdef PULSE_EMITTER_RANDGAP_EN
  // One extra bit so a jittered gap on a near-max cfg_gap cannot wrap.
  localparam int PH_W = CNT_WIDTH + 1;
`else
  localparam int PH_W = CNT_WIDTH;
`endif

  typedef logic [PH_W-1:0] ph_t;

  logic [1:0]           state_q, state_d;
  ph_t                  phase_q, phase_d;
  logic [CNT_WIDTH-1:0] wlim_q,  wlim_d;
  logic [CNT_WIDTH-1:0] glim_q,  glim_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 pend_q,  pend_d;
  logic                 pulse_q, pulse_d;
  logic                 done_q,  done_d;
  logic                 gap_end;

  // Terminal phase value for a configured length: max(v,1)-1.
  function automatic logic [CNT_WIDTH-1:0] norm_lim(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

`ifdef PULSE_EMITTER_RANDGAP_EN
  logic [15:0] lfsr_q, lfsr_d;
  ph_t         glen_q, glen_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    glen_d = glen_q;
    if (state_q == S_HIGH && state_d == S_GAP) begin
      glen_d = ph_t'(glim_q) + ph_t'(lfsr_q[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
      glen_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      glen_q <= glen_d;
    end
  end

  assign gap_end = (phase_q == glen_q);
`else
  assign gap_end = (phase_q == ph_t'(glim_q));
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wlim_d  = wlim_q;
    glim_d  = glim_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          wlim_d  = norm_lim(cfg_width);
          glim_d  = norm_lim(cfg_gap);
          count_d = cfg_count;
          cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          phase_d = '0;
          pulse_d = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        pend_d = pend_q | stop;
        if (phase_q == ph_t'(wlim_q)) begin
          phase_d = '0;
          pulse_d = 1'b0;
          // A stop seen on the final high cycle still ends the train cleanly.
          if ((cnt_q == count_q && count_q != '0) || pend_q || stop) begin
            pend_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_GAP: begin
        if (stop) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (gap_end) begin
          phase_d = '0;
          cnt_d   = sat_inc(cnt_q);
          pulse_d = 1'b1;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        phase_d = '0;
        pulse_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      wlim_q  <= '0;
      glim_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wlim_q  <= wlim_d;
      glim_q  <= glim_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_emitter.sv
// Directed bench for pulse_emitter; gap checks adapt to PULSE_EMITTER_RANDGAP_EN.
module tb_pulse_emitter;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, stop;
  logic [CW-1:0] cfg_width, cfg_gap, cfg_count;
  logic          o_pulse, busy, done;
  logic [CW-1:0] pulse_cnt;

  int n_vec = 0;
  int n_err = 0;
  int gl_cur[7];
  int gl_ref[7];

  always #5 clk = ~clk;

  pulse_emitter #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg_width (cfg_width),
    .cfg_gap   (cfg_gap),
    .cfg_count (cfg_count),
    .o_pulse   (o_pulse),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int g, input int c);
    cfg_width = CW'(w);
    cfg_gap   = CW'(g);
    cfg_count = CW'(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_level(input string tag, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, o_pulse, lvl);
      chk({tag, "_busy"}, busy, 1);
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input int cnt);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pulse"}, o_pulse, 0);
    chk({tag, "_cnt"}, pulse_cnt, cnt);
    tick();
    chk({tag, "_done_clr"}, done, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic gap_run(input string tag);
    int n;
    do_reset();
    set_cfg(1, 4, 8);
    pulse_start();
    for (int p = 0; p < 8; p++) begin
      chk({tag, "_hi"}, o_pulse, 1);
      tick();
      if (p < 7) begin
        n = 0;
        while (o_pulse == 1'b0 && n < 40) begin
          n++;
          tick();
        end
        gl_cur[p] = n;
`ifdef PULSE_EMITTER_RANDGAP_EN
        chk({tag, "_gap_range"}, (n >= 4 && n <= 19), 1);
`else
        chk({tag, "_gap4"}, n, 4);
`endif
      end
    end
    expect_done(tag, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(0, 0, 0);
    #12;
    chk("rst_pulse", o_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pulse_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // stop alone in IDLE does nothing
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_done", done, 0);

    // 3-high / 2-low, four pulses
    set_cfg(3, 2, 4);
    pulse_start();
    chk("t1_cnt_first", pulse_cnt, 1);
    for (int p = 0; p < 4; p++) begin
      expect_level("t1_hi", 1, 3);
      if (p < 3) expect_level("t1_lo", 0, 2);
    end
    expect_done("t1", 4);

    // zero width/gap normalised to 1; start+stop together in IDLE -> start wins
    set_cfg(0, 0, 2);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    expect_level("t2_hi", 1, 1);
    expect_level("t2_lo", 0, 1);
    expect_level("t2_hi", 1, 1);
    expect_done("t2", 2);

    // continuous train, stop in third gap
    set_cfg(2, 5, 0);
    pulse_start();
    for (int p = 0; p < 2; p++) begin
      expect_level("t3_hi", 1, 2);
      expect_level("t3_lo", 0, 5);
    end
    expect_level("t3_hi", 1, 2);
    expect_level("t3_lo", 0, 2);
    chk("t3_gap3_pulse", o_pulse, 0);
    chk("t3_gap3_cnt", pulse_cnt, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_done("t3", 3);
    for (int i = 0; i < 8; i++) chk("t3_quiet", o_pulse, 0);

    // stop on 2nd cycle of a 6-wide high: full-width pulse, then done
    set_cfg(6, 3, 0);
    pulse_start();
    expect_level("t4_hi", 1, 1);
    stop = 1'b1;
    expect_level("t4_hi", 1, 1);
    stop = 1'b0;
    expect_level("t4_hi", 1, 4);
    expect_done("t4", 1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_quiet", o_pulse, 0);
      chk("t4_quiet_busy", busy, 0);
      tick();
    end

    // config and start changes while busy are ignored
    set_cfg(3, 2, 3);
    pulse_start();
    expect_level("t5_hi", 1, 1);
    cfg_width = CW'(9);
    start = 1'b1;
    expect_level("t5_hi", 1, 1);
    start = 1'b0;
    expect_level("t5_hi", 1, 1);
    expect_level("t5_lo", 0, 2);
    expect_level("t5_hi", 1, 3);
    expect_level("t5_lo", 0, 2);
    expect_level("t5_hi", 1, 3);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", pulse_cnt, 3);
    // back-to-back: start taken in the done cycle
    set_cfg(2, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_b2b_rise", o_pulse, 1);
    chk("t5_b2b_cnt", pulse_cnt, 1);
    expect_level("t5_b2b_hi", 1, 2);
    expect_done("t5_b2b", 1);

    // asynchronous reset in the middle of a high phase
    set_cfg(5, 1, 0);
    pulse_start();
    expect_level("t6_hi", 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pulse", o_pulse, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_cnt", pulse_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_pulse", o_pulse, 0);

    // gap lengths, nominal gap 4
    gap_run("t7a");
`ifdef PULSE_EMITTER_RANDGAP_EN
    for (int i = 0; i < 7; i++) gl_ref[i] = gl_cur[i];
    gap_run("t7b");
    for (int i = 0; i < 7; i++) chk("t7_repeat", gl_cur[i], gl_ref[i]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
